// File: rtl/mips_exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU control decode, 32-bit ALU and EXE/MEM register.
// Optional signed-overflow flag for add/sub/addi is enabled with `define MIPS_EXE_OVERFLOW_EN.
module mips_exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [5:0]       instr_opcode,
  input  logic [5:0]       instr_funct,
  input  logic [WIDTH-1:0] alu_oprd1,
  input  logic [WIDTH-1:0] alu_oprd2,
  input  logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] reg_data2_e,
  input  logic [4:0]       write_reg_e,
  input  logic             reg_write_e,
  input  logic             mem_to_reg_e,
  input  logic             mem_write_e,
  input  logic             mem_read_e,
  input  logic             load_full_word_e,
  input  logic             load_signed_e,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero,
`ifdef MIPS_EXE_OVERFLOW_EN
  output logic             alu_overflow,
  output logic             alu_overflow_m,
`endif
  output logic [WIDTH-1:0] alu_result_m,
  output logic [WIDTH-1:0] reg_data2_m,
  output logic [4:0]       write_reg_m,
  output logic             reg_write_m,
  output logic             mem_to_reg_m,
  output logic             mem_write_m,
  output logic             mem_read_m,
  output logic             load_full_word_m,
  output logic             load_signed_m
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_LUI  = 4'd12;

  // ALU control: R-type selects by funct, everything else by opcode (loads/stores fall to ADD)
  always_comb begin
    alu_op = OP_ADD;
    if (instr_opcode == 6'h00) begin
      case (instr_funct)
        6'h20, 6'h21: alu_op = OP_ADD;
        6'h22, 6'h23: alu_op = OP_SUB;
        6'h24:        alu_op = OP_AND;
        6'h25:        alu_op = OP_OR;
        6'h26:        alu_op = OP_XOR;
        6'h27:        alu_op = OP_NOR;
        6'h2A:        alu_op = OP_SLT;
        6'h2B:        alu_op = OP_SLTU;
        6'h00:        alu_op = OP_SLL;
        6'h02:        alu_op = OP_SRL;
        6'h03:        alu_op = OP_SRA;
        default:      alu_op = OP_ADD;
      endcase
    end else begin
      case (instr_opcode)
        6'h08, 6'h09: alu_op = OP_ADD;
        6'h0C:        alu_op = OP_AND;
        6'h0D:        alu_op = OP_OR;
        6'h0E:        alu_op = OP_XOR;
        6'h0A:        alu_op = OP_SLT;
        6'h0B:        alu_op = OP_SLTU;
        6'h0F:        alu_op = OP_LUI;
        6'h04, 6'h05: alu_op = OP_SUB;
        default:      alu_op = OP_ADD;
      endcase
    end
  end

  logic signed [WIDTH-1:0] oprd1_s;
  logic signed [WIDTH-1:0] oprd2_s;
  logic        [WIDTH-1:0] sum;
  logic        [WIDTH-1:0] diff;

  assign oprd1_s = alu_oprd1;
  assign oprd2_s = alu_oprd2;
  assign sum     = alu_oprd1 + alu_oprd2;
  assign diff    = alu_oprd1 - alu_oprd2;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_AND:  alu_result = alu_oprd1 & alu_oprd2;
      OP_OR:   alu_result = alu_oprd1 | alu_oprd2;
      OP_ADD:  alu_result = sum;
      OP_XOR:  alu_result = alu_oprd1 ^ alu_oprd2;
      OP_NOR:  alu_result = ~(alu_oprd1 | alu_oprd2);
      OP_SUB:  alu_result = diff;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, (oprd1_s < oprd2_s)};
      OP_SLL:  alu_result = alu_oprd2 << alu_shamt;
      OP_SRL:  alu_result = alu_oprd2 >> alu_shamt;
      OP_SRA:  alu_result = oprd2_s >>> alu_shamt;
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (alu_oprd1 < alu_oprd2)};
      OP_LUI:  alu_result = {alu_oprd2[15:0], 16'h0000};
      default: alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == '0);

`ifdef MIPS_EXE_OVERFLOW_EN
  logic add_trap;
  logic sub_trap;
  logic add_ovf;
  logic sub_ovf;

  // Only the trapping encodings flag overflow; addu/subu/addiu wrap silently
  assign add_trap = ((instr_opcode == 6'h00) && (instr_funct == 6'h20)) || (instr_opcode == 6'h08);
  assign sub_trap =  (instr_opcode == 6'h00) && (instr_funct == 6'h22);
  assign add_ovf  = (alu_oprd1[WIDTH-1] == alu_oprd2[WIDTH-1]) && (sum[WIDTH-1]  != alu_oprd1[WIDTH-1]);
  assign sub_ovf  = (alu_oprd1[WIDTH-1] != alu_oprd2[WIDTH-1]) && (diff[WIDTH-1] != alu_oprd1[WIDTH-1]);
  assign alu_overflow = (add_trap && add_ovf) || (sub_trap && sub_ovf);
`endif

  // EXE/MEM pipeline register
  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic [WIDTH-1:0] reg_data2_d,  reg_data2_q;
  logic [4:0]       write_reg_d,  write_reg_q;
  logic [5:0]       ctrl_d,       ctrl_q;

  always_comb begin
    alu_result_d = alu_result_q;
    reg_data2_d  = reg_data2_q;
    write_reg_d  = write_reg_q;
    ctrl_d       = ctrl_q;
    if (write_en) begin
      alu_result_d = alu_result;
      reg_data2_d  = reg_data2_e;
      write_reg_d  = write_reg_e;
      ctrl_d       = {reg_write_e, mem_to_reg_e, mem_write_e,
                      mem_read_e, load_full_word_e, load_signed_e};
    end
  end

  // Reset clears data as well as controls so a flushed stage is a clean bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_q <= '0;
      reg_data2_q  <= '0;
      write_reg_q  <= '0;
      ctrl_q       <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      reg_data2_q  <= reg_data2_d;
      write_reg_q  <= write_reg_d;
      ctrl_q       <= ctrl_d;
    end
  end

`ifdef MIPS_EXE_OVERFLOW_EN
  logic overflow_d, overflow_q;

  assign overflow_d = write_en ? alu_overflow : overflow_q;

  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign alu_overflow_m = overflow_q;
`endif

  assign alu_result_m     = alu_result_q;
  assign reg_data2_m      = reg_data2_q;
  assign write_reg_m      = write_reg_q;
  assign reg_write_m      = ctrl_q[5];
  assign mem_to_reg_m     = ctrl_q[4];
  assign mem_write_m      = ctrl_q[3];
  assign mem_read_m       = ctrl_q[2];
  assign load_full_word_m = ctrl_q[1];
  assign load_signed_m    = ctrl_q[0];

endmodule

// File: tb/tb_mips_exe_stage.sv
// Directed bench for mips_exe_stage: ALU decode/result/zero and EXE/MEM register load, hold and flush.
module tb_mips_exe_stage;

  logic        clk = 1'b0;
  logic        reset, write_en;
  logic [5:0]  instr_opcode, instr_funct;
  logic [31:0] alu_oprd1, alu_oprd2, reg_data2_e;
  logic [4:0]  alu_shamt, write_reg_e;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e, load_full_word_e, load_signed_e;
  logic [3:0]  alu_op;
  logic [31:0] alu_result, alu_result_m, reg_data2_m;
  logic        alu_zero;
  logic [4:0]  write_reg_m;
  logic        reg_write_m, mem_to_reg_m, mem_write_m, mem_read_m, load_full_word_m, load_signed_m;
`ifdef MIPS_EXE_OVERFLOW_EN
  logic        alu_overflow, alu_overflow_m;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .write_en(write_en),
    .instr_opcode(instr_opcode), .instr_funct(instr_funct),
    .alu_oprd1(alu_oprd1), .alu_oprd2(alu_oprd2), .alu_shamt(alu_shamt),
    .reg_data2_e(reg_data2_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .mem_read_e(mem_read_e), .load_full_word_e(load_full_word_e), .load_signed_e(load_signed_e),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
`ifdef MIPS_EXE_OVERFLOW_EN
    .alu_overflow(alu_overflow), .alu_overflow_m(alu_overflow_m),
`endif
    .alu_result_m(alu_result_m), .reg_data2_m(reg_data2_m), .write_reg_m(write_reg_m),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m),
    .mem_read_m(mem_read_m), .load_full_word_m(load_full_word_m), .load_signed_m(load_signed_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    instr_opcode = op; instr_funct = fn; alu_oprd1 = a; alu_oprd2 = b; alu_shamt = sh;
    #1;
  endtask

  task automatic set_ctrl(input logic [5:0] c);
    {reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e, load_full_word_e, load_signed_e} = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ctrl_m();
    return {reg_write_m, mem_to_reg_m, mem_write_m, mem_read_m, load_full_word_m, load_signed_m};
  endfunction

  initial begin
    reset = 1'b1; write_en = 1'b1;
    reg_data2_e = 32'hDEAD_BEEF; write_reg_e = 5'd31;
    set_ctrl(6'b111111);
    set_alu(6'h08, 6'h00, 32'd1, 32'd2, 5'd0);
    tick; tick;
    check("rst_result_m", alu_result_m, 32'h0);
    check("rst_data2_m",  reg_data2_m,  32'h0);
    check("rst_wreg_m",   {27'h0, write_reg_m}, 32'h0);
    check("rst_ctrl_m",   {26'h0, ctrl_m()},    32'h0);

    reset = 1'b0;
    // addi: 0 + 5
    set_ctrl(6'b100000); write_reg_e = 5'd3; reg_data2_e = 32'd0;
    set_alu(6'h08, 6'h00, 32'd0, 32'd5, 5'd0);
    check("addi_op",   {28'h0, alu_op}, 32'd2);
    check("addi_res",  alu_result, 32'd5);
    check("addi_zero", {31'h0, alu_zero}, 32'd0);
    tick;
    check("addi_res_m",  alu_result_m, 32'd5);
    check("addi_rw_m",   {31'h0, reg_write_m}, 32'd1);
    check("addi_wreg_m", {27'h0, write_reg_m}, 32'd3);

    // beq compare
    set_alu(6'h04, 6'h00, 32'd5, 32'd5, 5'd0);
    check("beq_op",    {28'h0, alu_op}, 32'd6);
    check("beq_res",   alu_result, 32'd0);
    check("beq_zero",  {31'h0, alu_zero}, 32'd1);
    set_alu(6'h04, 6'h00, 32'd5, 32'd0, 5'd0);
    check("beq2_res",  alu_result, 32'd5);
    check("beq2_zero", {31'h0, alu_zero}, 32'd0);

    // shifts
    set_alu(6'h00, 6'h02, 32'd0, 32'd5, 5'd1);
    check("srl_op",  {28'h0, alu_op}, 32'd9);
    check("srl_res", alu_result, 32'd2);
    set_alu(6'h00, 6'h03, 32'd0, 32'h8000_0000, 5'd4);
    check("sra_op",  {28'h0, alu_op}, 32'd10);
    check("sra_res", alu_result, 32'hF800_0000);
    set_alu(6'h00, 6'h00, 32'd0, 32'd1, 5'd31);
    check("sll_res", alu_result, 32'h8000_0000);

    // signed vs unsigned compare
    set_alu(6'h00, 6'h2A, 32'hFFFF_FFFD, 32'd2, 5'd0);
    check("slt_op",   {28'h0, alu_op}, 32'd7);
    check("slt_res",  alu_result, 32'd1);
    set_alu(6'h00, 6'h2B, 32'hFFFF_FFFD, 32'd2, 5'd0);
    check("sltu_op",  {28'h0, alu_op}, 32'd11);
    check("sltu_res", alu_result, 32'd0);
    check("sltu_zero", {31'h0, alu_zero}, 32'd1);

    // logic ops, lui, default funct, add wraparound
    set_alu(6'h0F, 6'h00, 32'd0, 32'h1234_ABCD, 5'd0);
    check("lui_op",  {28'h0, alu_op}, 32'd12);
    check("lui_res", alu_result, 32'hABCD_0000);
    set_alu(6'h00, 6'h27, 32'd0, 32'd0, 5'd0);
    check("nor_res", alu_result, 32'hFFFF_FFFF);
    set_alu(6'h0E, 6'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    check("xori_res", alu_result, 32'h0FF0_0FF0);
    set_alu(6'h0C, 6'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    check("andi_res", alu_result, 32'hF000_F000);
    set_alu(6'h00, 6'h25, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
    check("or_res", alu_result, 32'hF0F0_0F0F);
    set_alu(6'h00, 6'h3F, 32'd1, 32'd2, 5'd0);
    check("dflt_op",  {28'h0, alu_op}, 32'd2);
    check("dflt_res", alu_result, 32'd3);
    set_alu(6'h00, 6'h23, 32'd3, 32'd5, 5'd0);
    check("subu_res", alu_result, 32'hFFFF_FFFE);
    set_alu(6'h00, 6'h21, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check("wrap_res",  alu_result, 32'd0);
    check("wrap_zero", {31'h0, alu_zero}, 32'd1);

`ifdef MIPS_EXE_OVERFLOW_EN
    check("addu_ovf", {31'h0, alu_overflow}, 32'd0);
    set_alu(6'h08, 6'h00, 32'h7FFF_FFFF, 32'd1, 5'd0);
    check("addi_ovf", {31'h0, alu_overflow}, 32'd1);
    tick;
    check("addi_ovf_m", {31'h0, alu_overflow_m}, 32'd1);
    set_alu(6'h00, 6'h22, 32'h8000_0000, 32'd1, 5'd0);
    check("sub_ovf", {31'h0, alu_overflow}, 32'd1);
`endif

    // load word: controls pass through
    set_ctrl(6'b110111); write_reg_e = 5'd9; reg_data2_e = 32'd0;
    set_alu(6'h23, 6'h00, 32'h100, 32'h4, 5'd0);
    check("lw_op", {28'h0, alu_op}, 32'd2);
    tick;
    check("lw_res_m",  alu_result_m, 32'h104);
    check("lw_ctrl_m", {26'h0, ctrl_m()}, 32'b110111);

    // store word
    set_ctrl(6'b001000); reg_data2_e = 32'd7; write_reg_e = 5'd0;
    set_alu(6'h2B, 6'h00, 32'd0, 32'd5, 5'd0);
    tick;
    check("sw_res_m",   alu_result_m, 32'd5);
    check("sw_data2_m", reg_data2_m,  32'd7);
    check("sw_ctrl_m",  {26'h0, ctrl_m()}, 32'b001000);

    // hold with write_en low
    write_en = 1'b0;
    set_ctrl(6'b110000); reg_data2_e = 32'd9; write_reg_e = 5'd12;
    set_alu(6'h08, 6'h00, 32'd100, 32'd1, 5'd0);
    tick;
    check("hold_res_m",   alu_result_m, 32'd5);
    check("hold_data2_m", reg_data2_m,  32'd7);
    check("hold_wreg_m",  {27'h0, write_reg_m}, 32'd0);
    check("hold_ctrl_m",  {26'h0, ctrl_m()}, 32'b001000);

    // mid-stream flush
    write_en = 1'b1; reset = 1'b1;
    tick;
    check("flush_res_m",   alu_result_m, 32'h0);
    check("flush_data2_m", reg_data2_m,  32'h0);
    check("flush_wreg_m",  {27'h0, write_reg_m}, 32'h0);
    check("flush_ctrl_m",  {26'h0, ctrl_m()}, 32'h0);
    reset = 1'b0;

    // nop instruction
    set_alu(6'h00, 6'h00, 32'd0, 32'd0, 5'd0);
    check("nop_op",   {28'h0, alu_op}, 32'd8);
    check("nop_res",  alu_result, 32'd0);
    check("nop_zero", {31'h0, alu_zero}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mips_exe_stage.md
Name: mips_exe_stage

Overview:
- Execute-stage datapath slice of the 5-stage MIPS pipeline.
- Decodes opcode/funct into a 4-bit ALU operation and performs the 32-bit ALU operation combinationally.
- Registers the ALU result and memory/write-back controls into the EXE/MEM pipeline register for the MEMORY stage.
- Operand forwarding and the ALUSrc mux are upstream; branch decision (branch & zero) is downstream.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears the pipeline register
- write_en  in  1  pipeline register load enable (tied 1 in normal operation)
- instr_opcode  in  6  instruction[31:26]
- instr_funct  in  6  instruction[5:0]
- alu_oprd1  in  32  operand A (forwarded rs)
- alu_oprd2  in  32  operand B (forwarded rt or immediate)
- alu_shamt  in  5  shift amount
- reg_data2_e  in  32  forwarded rt value, used as store data
- write_reg_e  in  5  destination register
- reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e, load_full_word_e, load_signed_e  in  1 each  controls passed to MEM
- alu_op  out  4  decoded ALU op (combinational)
- alu_result  out  32  combinational result
- alu_zero  out  1  high when alu_result == 0 (combinational)
- alu_result_m, reg_data2_m  out  32 each  registered
- write_reg_m  out  5  registered
- reg_write_m, mem_to_reg_m, mem_write_m, mem_read_m, load_full_word_m, load_signed_m  out  1 each  registered

Behaviour:
- ALU op encoding: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT, 8 SLL, 9 SRL, 10 SRA, 11 SLTU, 12 LUI. Unlisted codes produce result 0.
- Controller, opcode 0x00 (R-type), by funct:
  - 0x20/0x21 ADD; 0x22/0x23 SUB
  - 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR
  - 0x2A SLT; 0x2B SLTU
  - 0x00 SLL; 0x02 SRL; 0x03 SRA
  - any other funct: ADD
- Controller, other opcodes:
  - 0x08/0x09 ADD; 0x0C AND; 0x0D OR; 0x0E XOR
  - 0x0A SLT; 0x0B SLTU; 0x0F LUI
  - 0x04/0x05 (beq/bne) SUB
  - loads 0x20,0x21,0x23,0x24,0x25 and stores 0x28,0x29,0x2B: ADD
  - any other opcode: ADD
- Arithmetic and shift rules:
  - ADD/SUB are modulo 2^32; no exception.
  - SLT is a signed compare, SLTU unsigned; result is 32'd1 or 32'd0.
  - Shifts act on alu_oprd2 by alu_shamt: SRA is arithmetic; SRL/SLL zero-fill.
  - LUI result = {alu_oprd2[15:0], 16'h0}.
- alu_zero reflects alu_result for every op.
- Instruction 0x00000000 (nop = SLL 0 by 0) yields result 0, zero=1.
- Pipeline register, on each posedge clk:
  - reset=1: all *_m outputs <= 0. Reset overrides write_en.
  - else write_en=1: capture alu_result, reg_data2_e, write_reg_e and all six controls.
  - else: hold.
- Latency: combinational outputs settle in the same cycle; *_m outputs appear 1 cycle later.
- Registered outputs are 0 after reset. There is no X-propagation from an unreset state once reset has been applied.
- Reset asserted mid-stream flushes the stage to a bubble: all controls 0, so no memory or register write occurs.

Optional Feature:
- Macro: MIPS_EXE_OVERFLOW_EN.
- When defined:
  - Adds output alu_overflow (1 bit, combinational): high for ADD/SUB signed two's-complement overflow, only when funct/opcode is the trapping form (add 0x20, sub 0x22, addi 0x08); otherwise 0.
  - Adds registered alu_overflow_m, reset to 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- opcode 0x08, A=0, B=5 -> alu_op=2, result=5, zero=0; next edge alu_result_m=5, reg_write_m=1 when reg_write_e=1.
- opcode 0x04, A=5, B=5 -> alu_op=6, result=0, zero=1. Then A=5, B=0 -> result=5, zero=0.
- R-type funct 0x02, B=5, shamt=1 -> SRL result=2. Funct 0x03, B=0x80000000, shamt=4 -> 0xF8000000.
- R-type funct 0x2A, A=0xFFFFFFFD, B=2 -> SLT result=1. Funct 0x2B, same operands -> 0.
- Store path: opcode 0x2B, A=0, B=5, reg_data2_e=7, mem_write_e=1 -> after edge alu_result_m=5, reg_data2_m=7, mem_write_m=1. Then reset=1 with write_en=1 -> all *_m = 0 next edge.
- write_en=0 with changing inputs -> *_m hold previous values. Instruction 0x00000000 -> result 0, zero=1.
